// File: rtl/unsigned_mac_accumulator.sv
// Unsigned multiply-accumulate over a start/len job; 2-stage pipeline, result 2 cycles after last beat.
// in_ready only in ACC; result held in DONE until out_ready. MAC_ACC_SATURATE_EN selects saturating add.
module unsigned_mac_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 2*N+2,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [2*N-1:0]   prod_q;
  logic             prod_v;
  logic [LEN_W-1:0] remaining;
  logic             ovf_q;

  logic [2*N-1:0]   prod_d;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;

  always_comb begin
    prod_d   = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    prod_ext = {{(ACC_W+1-2*N){1'b0}}, prod_q};
    sum      = {1'b0, acc} + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else begin
      prod_v <= 1'b0;
      // Second pipeline stage: fold the registered product into the accumulator.
      if (prod_v) begin
`ifdef MAC_ACC_SATURATE_EN
        acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc <= sum[ACC_W-1:0];
`endif
        if (sum[ACC_W]) ovf_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf_q     <= 1'b0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            remaining <= len;
            state     <= (len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            prod_q    <= prod_d;
            prod_v    <= 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN:   state <= DONE;
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_unsigned_mac_accumulator.sv
// Bench for unsigned_mac_accumulator: directed scenarios plus random jobs against a sum-of-products model.
module tb_unsigned_mac_accumulator;
  localparam int N     = 4;
  localparam int ACC_W = 10;
  localparam int LEN_W = 4;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     x = '0;
  logic [N-1:0]     y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  unsigned_mac_accumulator #(.N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int bx[$];
  int by[$];

  logic [ACC_W-1:0] obs_acc;
  logic             obs_ovf;
  bit               obs_lat_ok, obs_stable, obs_inrdy_low, obs_idle, obs_timeout;

  // Reference: exact sum of products, then reduced by the build's overflow rule.
  function automatic void model(input int n, output logic [ACC_W-1:0] e_acc, output logic e_ovf);
    longint total = 0;
    longint r;
    for (int i = 0; i < n; i++) total += longint'(bx[i]) * longint'(by[i]);
    e_ovf = (total > MAXV);
`ifdef MAC_ACC_SATURATE_EN
    r = e_ovf ? MAXV : total;
`else
    r = total % (MAXV + 1);
`endif
    e_acc = r[ACC_W-1:0];
  endfunction

  // Runs one job from the beat queues; all sampling happens on the falling edge.
  task automatic drive_job(input int len_v, input int gap_min, input int gap_max,
                           input int hold, input bit poke_start);
    int cyc;
    obs_lat_ok = 1; obs_stable = 1; obs_inrdy_low = 1; obs_timeout = 0;
    start = 1'b1; len = LEN_W'(len_v);
    @(negedge clk);
    start = poke_start;
    for (int i = 0; i < len_v; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
      in_valid = 1'b1; x = N'(bx[i]); y = N'(by[i]);
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) obs_timeout = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (len_v > 0) begin
      if (out_valid !== 1'b0) obs_lat_ok = 0;
      @(negedge clk);
    end
    start = 1'b0;
    if (out_valid !== 1'b1) obs_lat_ok = 0;
    obs_acc = acc_out; obs_ovf = overflow;
    repeat (hold) begin
      @(negedge clk);
      if (acc_out !== obs_acc || overflow !== obs_ovf || out_valid !== 1'b1) obs_stable = 0;
      if (in_ready !== 1'b0) obs_inrdy_low = 0;
    end
    out_ready = 1'b1; start = poke_start;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    obs_idle = (busy === 1'b0 && out_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 4'd3; in_valid = 1'b1; x = 4'd9; y = 4'd9; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_hold: busy got %b want 0", busy); end
  endtask

  task automatic test_full_scale();
    logic [ACC_W-1:0] e_acc; logic e_ovf;
    bx = '{15, 15, 15, 15}; by = '{15, 15, 15, 15};
    model(4, e_acc, e_ovf);
    drive_job(4, 0, 0, 0, 0);
    n_cmp++; if (obs_acc !== e_acc) begin n_err++; $display("FAIL full_scale_acc: got %0d want %0d", obs_acc, e_acc); end
    n_cmp++; if (obs_acc !== 10'd900) begin n_err++; $display("FAIL full_scale_900: got %0d want 900", obs_acc); end
    n_cmp++; if (obs_ovf !== e_ovf) begin n_err++; $display("FAIL full_scale_ovf: got %b want %b", obs_ovf, e_ovf); end
    n_cmp++; if (obs_lat_ok !== 1'b1 || obs_timeout !== 1'b0) begin n_err++; $display("FAIL full_scale_latency: lat_ok %b timeout %b want 1 0", obs_lat_ok, obs_timeout); end
    n_cmp++; if (obs_idle !== 1'b1) begin n_err++; $display("FAIL full_scale_idle: got %b want 1", obs_idle); end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] e_acc;
    bx = '{15, 15, 15, 15, 15}; by = '{15, 15, 15, 15, 15};
`ifdef MAC_ACC_SATURATE_EN
    e_acc = 10'd1023;
`else
    e_acc = 10'd101;
`endif
    drive_job(5, 0, 1, 1, 0);
    n_cmp++; if (obs_acc !== e_acc) begin n_err++; $display("FAIL overflow_acc: got %0d want %0d", obs_acc, e_acc); end
    n_cmp++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b want 1", obs_ovf); end
    // The next job must start with the sticky flag cleared.
    bx = '{1}; by = '{2};
    drive_job(1, 0, 0, 0, 0);
    n_cmp++; if (obs_ovf !== 1'b0 || obs_acc !== 10'd2) begin n_err++; $display("FAIL overflow_cleared: got acc %0d ovf %b want 2 0", obs_acc, obs_ovf); end
  endtask

  task automatic test_gaps_backpressure();
    bx = '{2, 4, 1}; by = '{3, 5, 1};
    drive_job(3, 1, 3, 5, 0);
    n_cmp++; if (obs_acc !== 10'd27) begin n_err++; $display("FAIL gaps_acc: got %0d want 27", obs_acc); end
    n_cmp++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL gaps_stable: got %b want 1", obs_stable); end
    n_cmp++; if (obs_inrdy_low !== 1'b1) begin n_err++; $display("FAIL gaps_in_ready_done: got %b want 1", obs_inrdy_low); end
    n_cmp++; if (obs_lat_ok !== 1'b1 || obs_timeout !== 1'b0) begin n_err++; $display("FAIL gaps_latency: lat_ok %b timeout %b want 1 0", obs_lat_ok, obs_timeout); end
    n_cmp++; if (obs_idle !== 1'b1) begin n_err++; $display("FAIL gaps_idle: got %b want 1", obs_idle); end
  endtask

  task automatic test_len_zero();
    in_valid = 1'b1; x = 4'd7; y = 4'd7;
    drive_job(0, 0, 0, 2, 0);
    in_valid = 1'b0;
    n_cmp++; if (obs_lat_ok !== 1'b1) begin n_err++; $display("FAIL len0_latency: got %b want 1", obs_lat_ok); end
    n_cmp++; if (obs_acc !== '0) begin n_err++; $display("FAIL len0_acc: got %0d want 0", obs_acc); end
    n_cmp++; if (obs_inrdy_low !== 1'b1) begin n_err++; $display("FAIL len0_in_ready: got %b want 1", obs_inrdy_low); end
  endtask

  task automatic test_reset_midjob();
    bit seen_valid = 0;
    start = 1'b1; len = 4'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x = 4'd5; y = 4'd5;
    @(negedge clk);
    x = 4'd6; y = 4'd6;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || acc_out !== '0) begin n_err++; $display("FAIL midjob_reset: busy %b acc %0d want 0 0", busy, acc_out); end
    repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) seen_valid = 1; end
    n_cmp++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL midjob_no_result: got %b want 0", seen_valid); end
    bx = '{3}; by = '{3};
    drive_job(1, 0, 0, 0, 0);
    n_cmp++; if (obs_acc !== 10'd9) begin n_err++; $display("FAIL midjob_next_acc: got %0d want 9", obs_acc); end
  endtask

  task automatic test_start_ignored();
    logic [ACC_W-1:0] e_acc; logic e_ovf;
    bx = '{3, 7, 2, 9}; by = '{4, 1, 8, 2};
    model(4, e_acc, e_ovf);
    drive_job(4, 0, 2, 2, 1);
    n_cmp++; if (obs_acc !== e_acc) begin n_err++; $display("FAIL start_ignored_acc: got %0d want %0d", obs_acc, e_acc); end
    n_cmp++; if (obs_idle !== 1'b1) begin n_err++; $display("FAIL start_ignored_idle: got %b want 1", obs_idle); end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] e_acc; logic e_ovf;
    int n;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(15, 0);
      bx = {}; by = {};
      for (int i = 0; i < n; i++) begin
        bx.push_back($urandom_range(15, 0));
        by.push_back($urandom_range(15, 0));
      end
      model(n, e_acc, e_ovf);
      drive_job(n, 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      n_cmp++; if (obs_acc !== e_acc || obs_ovf !== e_ovf) begin n_err++; $display("FAIL random_job%0d: got acc %0d ovf %b want %0d %b", j, obs_acc, obs_ovf, e_acc, e_ovf); end
      n_cmp++; if (obs_lat_ok !== 1'b1 || obs_timeout !== 1'b0 || obs_idle !== 1'b1) begin n_err++; $display("FAIL random_flow%0d: lat_ok %b timeout %b idle %b want 1 0 1", j, obs_lat_ok, obs_timeout, obs_idle); end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_overflow();
    test_gaps_backpressure();
    test_len_zero();
    test_reset_midjob();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unsigned_mac_accumulator.md
UNSIGNED_MAC_ACCUMULATOR -- requirements
Module: unsigned_mac_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, the operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 2*N+2, the accumulator width in bits; legal values are ACC_W >= 2*N.
REQ-003 SHALL have parameter LEN_W, default 4, the width of the beat-count field.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begins a job; sampled in IDLE only.
REQ-007 SHALL have port len, input, LEN_W bits: number of operand beats in the job; sampled with start.
REQ-008 SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-010 SHALL have port x, input, N bits: unsigned operand.
REQ-011 SHALL have port y, input, N bits: unsigned operand.
REQ-012 SHALL have port out_valid, output, 1 bit: acc_out holds the job result.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 SHALL have port acc_out, output, ACC_W bits: the accumulated sum of products.
REQ-015 SHALL have port overflow, output, 1 bit: sticky per job; the sum exceeded 2^ACC_W-1.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ACC, DRAIN and DONE.
REQ-018 In IDLE with start=1, SHALL clear the accumulator, overflow and the product stage, load remaining=len, and go to ACC; if len=0, it SHALL go to DONE instead.
REQ-019 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-020 In ACC, in_ready SHALL be 1; a beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-021 An accepted beat SHALL register the 2N-bit product x*y into prod_q with prod_v=1 at the same edge; otherwise prod_v SHALL be 0 at that edge.
REQ-022 When prod_v=1, the block SHALL add zero-extended prod_q to the accumulator one edge later (2-stage pipeline).
REQ-023 Each accepted beat SHALL decrement remaining; the last beat (remaining=1) SHALL move the FSM to DRAIN.
REQ-024 DRAIN SHALL last exactly one cycle, in which the final product is accumulated, and SHALL then move the FSM to DONE.
REQ-025 out_valid SHALL therefore rise exactly 2 cycles after the edge that accepted the last beat.
REQ-026 In ACC, a cycle with in_valid=0 SHALL neither advance remaining nor change the final sum; gaps between beats are unlimited.
REQ-027 In DONE, out_valid SHALL be 1 and acc_out and overflow SHALL be held stable until out_valid and out_ready are both 1; the FSM SHALL then go to IDLE.
REQ-028 start SHALL be ignored outside IDLE, including in the cycle of the DONE handshake; the next job may start one cycle after that handshake.
REQ-029 in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-030 The add SHALL be computed at ACC_W+1 bits; a carry-out SHALL set overflow, which stays set until the next job starts.
REQ-031 Without saturation, the accumulator SHALL keep the sum modulo 2^ACC_W.

Reset
REQ-032 When rst=1 at a rising clk edge, the block SHALL enter IDLE and clear the accumulator, prod_q, prod_v, remaining and overflow to 0.
REQ-033 During and after reset, in_ready, out_valid, busy and acc_out SHALL read 0.
REQ-034 Reset SHALL take priority over every other input.
REQ-035 Reset mid-job SHALL abandon the job with no out_valid pulse for it.

Configuration
REQ-036 With macro MAC_ACC_SATURATE_EN defined, an add with carry-out SHALL set the accumulator to 2^ACC_W-1 and set overflow.
REQ-037 With MAC_ACC_SATURATE_EN defined, the accumulator SHALL stay at 2^ACC_W-1 for the rest of the job.
REQ-038 With MAC_ACC_SATURATE_EN undefined, the block SHALL wrap per REQ-031; overflow SHALL behave identically in both builds.

Verification (defaults N=4, ACC_W=10)
REQ-039 start, len=4, four back-to-back beats x=15 y=15 -> out_valid 2 cycles after the 4th accept, acc_out=900, overflow=0.
REQ-040 len=5, five beats x=15 y=15 -> wrap build: acc_out=101, overflow=1; MAC_ACC_SATURATE_EN build: acc_out=1023, overflow=1.
REQ-041 len=3, beats (2,3),(4,5),(1,1) with idle cycles between beats and out_ready held 0 for 5 cycles -> acc_out=27 stable throughout, in_ready=0 while in DONE, return to IDLE 1 cycle after out_ready=1.
REQ-042 start with len=0 -> out_valid next cycle, acc_out=0, no beat accepted.
REQ-043 rst=1 after 2 of 4 beats, then a new job len=1 with beat (3,3) -> no result from the aborted job, then acc_out=9.
REQ-044 start pulsed in ACC and in the DONE handshake cycle -> ignored; the job count and result are unchanged.
